univ_shift_reg: RTL and testbench

Parametrised universal shift register: DEPTH stages of WIDTH bits each, with hold, shift-right, shift-left and parallel-load modes and a per-stage valid bit tracking which stages hold real data. It is the general-purpose successor to the fixed 4-stage, 1-bit serial-in/serial-out chain. It serves serialisers, deserialisers and delay lines elsewhere in the design. With WIDTH=1, DEPTH=4 and mode fixed at shift-right, it reproduces the plain 4-deep SISO chain.

---
 rtl/shreg_pkg.sv | 17 +
 rtl/univ_shift_reg_if.sv | 36 +++
 rtl/shreg_stage.sv | 66 ++++++
 rtl/univ_shift_reg.sv | 110 +++++++++++
 tb/tb_univ_shift_reg.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register: operating modes and
// the width of the fill counter.
package shreg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Bits needed to count from 0 to depth inclusive.
    function automatic int fill_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register. The master drives
// mode, serial and parallel inputs; the slave (the register) returns the
// stage contents, serial outputs, valid flags and occupancy.
interface univ_shift_reg_if
    import shreg_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
);
    localparam int FILL_W = fill_w(DEPTH);

    logic                     en;
    logic                     clr;
    logic [1:0]               mode;
    logic [WIDTH-1:0]         sin_r;
    logic [WIDTH-1:0]         sin_l;
    logic [WIDTH*DEPTH-1:0]   pin;
    logic [WIDTH*DEPTH-1:0]   pout;
    logic [WIDTH-1:0]         sout_r;
    logic [WIDTH-1:0]         sout_l;
    logic                     sout_r_valid;
    logic                     sout_l_valid;
    logic [FILL_W-1:0]        fill;
    logic                     full;

    modport master (
        output en, clr, mode, sin_r, sin_l, pin,
        input  pout, sout_r, sout_l, sout_r_valid, sout_l_valid, fill, full
    );

    modport slave (
        input  en, clr, mode, sin_r, sin_l, pin,
        output pout, sout_r, sout_l, sout_r_valid, sout_l_valid, fill, full
    );

endinterface

// File: rtl/shreg_stage.sv
// One stage of the universal shift register: a WIDTH-bit data flop plus a
// valid flop. The left neighbour is stage i-1 (feeds a right shift), the
// right neighbour is stage i+1 (feeds a left shift).
module shreg_stage
    import shreg_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] left_d,
    input  logic             left_v,
    input  logic [WIDTH-1:0] right_d,
    input  logic             right_v,
    input  logic [WIDTH-1:0] load_d,
    output logic [WIDTH-1:0] q,
    output logic             v
);

    logic [WIDTH-1:0] d_nxt;
    logic             v_nxt;

    // Next-value select: hold unless enabled, then pick by mode.
    always_comb begin
        d_nxt = q;
        v_nxt = v;
        if (en) begin
            case (mode)
                MODE_SHR: begin
                    d_nxt = left_d;
                    v_nxt = left_v;
                end
                MODE_SHL: begin
                    d_nxt = right_d;
                    v_nxt = right_v;
                end
                MODE_LOAD: begin
                    d_nxt = load_d;
                    v_nxt = 1'b1;
                end
                default: begin
                    d_nxt = q;
                    v_nxt = v;
                end
            endcase
        end
    end

    // Stage register: async reset, then sync clear, then the selected value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
            v <= 1'b0;
        end else if (clr) begin
            q <= '0;
            v <= 1'b0;
        end else begin
            q <= d_nxt;
            v <= v_nxt;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: DEPTH stages of WIDTH bits with hold, shift-right,
// shift-left and parallel load. Each stage carries a valid bit; a registered
// fill counter tracks how many stages hold real data (gaps allowed).
module univ_shift_reg
    import shreg_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    univ_shift_reg_if.slave   bus
);

    localparam int FILL_W = fill_w(DEPTH);

    logic [WIDTH-1:0] stage_d [DEPTH];
    logic             stage_v [DEPTH];
    logic [WIDTH-1:0] left_d  [DEPTH];
    logic             left_v  [DEPTH];
    logic [WIDTH-1:0] right_d [DEPTH];
    logic             right_v [DEPTH];

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            // Stage 0 takes sin_r on a right shift; a serial word is always valid.
            if (i == 0) begin : g_left_edge
                assign left_d[i] = bus.sin_r;
                assign left_v[i] = 1'b1;
            end else begin : g_left_inner
                assign left_d[i] = stage_d[i-1];
                assign left_v[i] = stage_v[i-1];
            end

            // Last stage takes sin_l on a left shift.
            if (i == DEPTH - 1) begin : g_right_edge
                assign right_d[i] = bus.sin_l;
                assign right_v[i] = 1'b1;
            end else begin : g_right_inner
                assign right_d[i] = stage_d[i+1];
                assign right_v[i] = stage_v[i+1];
            end

            shreg_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .clr     (bus.clr),
                .en      (bus.en),
                .mode    (bus.mode),
                .left_d  (left_d[i]),
                .left_v  (left_v[i]),
                .right_d (right_d[i]),
                .right_v (right_v[i]),
                .load_d  (bus.pin[i*WIDTH +: WIDTH]),
                .q       (stage_d[i]),
                .v       (stage_v[i])
            );

            assign bus.pout[i*WIDTH +: WIDTH] = stage_d[i];
        end
    endgenerate

    assign bus.sout_r       = stage_d[DEPTH-1];
    assign bus.sout_l       = stage_d[0];
    assign bus.sout_r_valid = stage_v[DEPTH-1];
    assign bus.sout_l_valid = stage_v[0];

    logic [FILL_W-1:0] fill_q;
    logic              full_q;
    logic [FILL_W:0]   fill_ext;
    logic [FILL_W-1:0] fill_nxt;

    // Occupancy update: a shift adds one valid word and drops whatever valid
    // bit falls off the far end; the extra bit keeps DEPTH+1 from wrapping.
    always_comb begin
        fill_ext = {1'b0, fill_q};
        if (bus.en) begin
            case (bus.mode)
                MODE_SHR:  fill_ext = {1'b0, fill_q} + (FILL_W+1)'(1)
                                      - (FILL_W+1)'(stage_v[DEPTH-1]);
                MODE_SHL:  fill_ext = {1'b0, fill_q} + (FILL_W+1)'(1)
                                      - (FILL_W+1)'(stage_v[0]);
                MODE_LOAD: fill_ext = (FILL_W+1)'(DEPTH);
                default:   fill_ext = {1'b0, fill_q};
            endcase
        end
        fill_nxt = fill_ext[FILL_W-1:0];
    end

    // Fill and full registers; full is set on the same edge fill reaches DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= '0;
            full_q <= 1'b0;
        end else if (bus.clr) begin
            fill_q <= '0;
            full_q <= 1'b0;
        end else begin
            fill_q <= fill_nxt;
            full_q <= (fill_nxt == FILL_W'(DEPTH));
        end
    end

    assign bus.fill = fill_q;
    assign bus.full = full_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: an 8-bit and a 1-bit instance (both 4 deep) run
// in lockstep against a queue-based model of the register contents.
`timescale 1ns/1ps
module tb_univ_shift_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #10 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(8), .DEPTH(4)) b8 ();
    univ_shift_reg_if #(.WIDTH(1), .DEPTH(4)) b1 ();

    univ_shift_reg #(.WIDTH(8), .DEPTH(4)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    univ_shift_reg #(.WIDTH(1), .DEPTH(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } cell_t;

    // mq[0] is stage 0 (sin_r end), mq[3] is stage 3 (sin_l end).
    cell_t mq[$];
    int    checks = 0;
    int    errors = 0;
    bit    cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_pout8();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = mq[i].d;
        return r;
    endfunction

    function automatic logic [31:0] m_pout1();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i] = mq[i].d[0];
        return r;
    endfunction

    function automatic logic [31:0] m_vvec();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i] = mq[i].v;
        return r;
    endfunction

    function automatic logic [31:0] m_fill();
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) if (mq[i].v) n++;
        return 32'(n);
    endfunction

    task automatic m_reset();
        cell_t z;
        z = '0;
        mq.delete();
        for (int i = 0; i < 4; i++) mq.push_back(z);
    endtask

    task automatic m_step(input logic en, input logic clr, input logic [1:0] mode,
                          input logic [7:0] sr, input logic [7:0] sl, input logic [31:0] pin);
        cell_t c;
        if (clr) begin
            m_reset();
        end else if (en) begin
            case (mode)
                2'b01: begin
                    c.d = sr; c.v = 1'b1;
                    mq.push_front(c);
                    void'(mq.pop_back());
                end
                2'b10: begin
                    c.d = sl; c.v = 1'b1;
                    mq.push_back(c);
                    void'(mq.pop_front());
                end
                2'b11: begin
                    for (int i = 0; i < 4; i++) begin
                        mq[i].d = pin[i*8 +: 8];
                        mq[i].v = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic drive(input logic en, input logic clr, input logic [1:0] mode,
                         input logic [7:0] sr, input logic [7:0] sl, input logic [31:0] pin);
        b8.en = en;  b8.clr = clr;  b8.mode = mode;
        b8.sin_r = sr; b8.sin_l = sl; b8.pin = pin;
        b1.en = en;  b1.clr = clr;  b1.mode = mode;
        b1.sin_r = sr[0]; b1.sin_l = sl[0];
        b1.pin = {pin[24], pin[16], pin[8], pin[0]};
    endtask

    // One clock: inputs applied after a falling edge, model advanced after the rising edge.
    task automatic step(input logic en, input logic clr, input logic [1:0] mode,
                        input logic [7:0] sr, input logic [7:0] sl, input logic [31:0] pin);
        @(negedge clk);
        drive(en, clr, mode, sr, sl, pin);
        @(posedge clk);
        #1;
        m_step(en, clr, mode, sr, sl, pin);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 32'h0);
        #3;
        rst = 1'b1;
        m_reset();
        #2;
        chk("rst_pout8",  b8.pout, 32'h0);
        chk("rst_pout1",  32'(b1.pout), 32'h0);
        chk("rst_fill",   32'(b8.fill), 32'h0);
        chk("rst_full",   32'(b8.full), 32'h0);
        chk("rst_vr",     32'(b8.sout_r_valid), 32'h0);
        chk("rst_vl",     32'(b8.sout_l_valid), 32'h0);
        #2;
        rst = 1'b0;
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("pout8",   b8.pout, m_pout8());
            chk("sout_r8", 32'(b8.sout_r), 32'(mq[3].d));
            chk("sout_l8", 32'(b8.sout_l), 32'(mq[0].d));
            chk("vr8",     32'(b8.sout_r_valid), 32'(mq[3].v));
            chk("vl8",     32'(b8.sout_l_valid), 32'(mq[0].v));
            chk("fill8",   32'(b8.fill), m_fill());
            chk("full8",   32'(b8.full), 32'(m_fill() == 32'd4));
            chk("pout1",   32'(b1.pout), m_pout1());
            chk("sout_r1", 32'(b1.sout_r), 32'(mq[3].d[0]));
            chk("sout_l1", 32'(b1.sout_l), 32'(mq[0].d[0]));
            chk("fill1",   32'(b1.fill), m_fill());
            chk("full1",   32'(b1.full), 32'(m_fill() == 32'd4));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        do_reset();
        cmp_on = 1'b1;

        // SISO behaviour: 1,0,1,1 shifted right into the 1-bit instance.
        step(1'b1, 1'b0, 2'b01, 8'h01, 8'h00, 32'h0);
        step(1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 32'h0);
        step(1'b1, 1'b0, 2'b01, 8'h01, 8'h00, 32'h0);
        chk("siso_early_sout_r", 32'(b1.sout_r), 32'h0);
        chk("siso_early_vr", 32'(b1.sout_r_valid), 32'h0);
        step(1'b1, 1'b0, 2'b01, 8'h01, 8'h00, 32'h0);
        chk("siso_model", m_pout1(), 32'hB);
        chk("siso_pout", 32'(b1.pout), 32'hB);
        chk("siso_sout_r", 32'(b1.sout_r), 32'h1);
        chk("siso_fill", 32'(b1.fill), 32'd4);
        chk("siso_full", 32'(b1.full), 32'd1);

        // Parallel load then shifts in both directions.
        do_reset();
        step(1'b1, 1'b0, 2'b11, 8'h00, 8'h00, 32'hDDCCBBAA);
        chk("load_pout", b8.pout, 32'hDDCCBBAA);
        step(1'b1, 1'b0, 2'b01, 8'h11, 8'h00, 32'h0);
        chk("shr_model", m_pout8(), 32'hCCBBAA11);
        chk("shr_pout", b8.pout, 32'hCCBBAA11);
        chk("shr_sout_r", 32'(b8.sout_r), 32'hCC);
        chk("shr_fill", 32'(b8.fill), 32'd4);
        step(1'b1, 1'b0, 2'b10, 8'h00, 8'h22, 32'h0);
        chk("shl_pout", b8.pout, 32'h22CCBBAA);
        chk("shl_sout_l", 32'(b8.sout_l), 32'hAA);

        // Valid gaps from mixed-direction shifts.
        do_reset();
        step(1'b1, 1'b0, 2'b01, 8'h05, 8'h00, 32'h0);
        step(1'b1, 1'b0, 2'b01, 8'h06, 8'h00, 32'h0);
        chk("gap_model_v1", m_vvec(), 32'h3);
        chk("gap_fill1", 32'(b8.fill), 32'd2);
        step(1'b1, 1'b0, 2'b10, 8'h00, 8'h07, 32'h0);
        chk("gap_model_v2", m_vvec(), 32'h9);
        chk("gap_fill2", 32'(b8.fill), 32'd2);
        chk("gap_vl", 32'(b8.sout_l_valid), 32'd1);
        chk("gap_vr", 32'(b8.sout_r_valid), 32'd1);
        step(1'b1, 1'b0, 2'b00, 8'h99, 8'h99, 32'hFFFFFFFF);
        step(1'b1, 1'b0, 2'b10, 8'h00, 8'h08, 32'h0);

        // Fill saturation over six right shifts.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0, 2'b01, 8'(k * 16 + k), 8'h00, 32'h0);
            chk("sat_fill", 32'(b8.fill), (k >= 4) ? 32'd4 : 32'(k));
            chk("sat_full", 32'(b8.full), (k >= 4) ? 32'd1 : 32'd0);
        end

        // Clear beats load; disabled shifts leave everything alone.
        step(1'b1, 1'b0, 2'b11, 8'h00, 8'h00, 32'h12345678);
        step(1'b1, 1'b1, 2'b11, 8'h00, 8'h00, 32'hFFFFFFFF);
        chk("clr_pout", b8.pout, 32'h0);
        chk("clr_fill", 32'(b8.fill), 32'd0);
        step(1'b1, 1'b0, 2'b11, 8'h00, 8'h00, 32'hA5A55A5A);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 2'b01, 8'hFF, 8'hFF, 32'h0);
        chk("hold_pout", b8.pout, 32'hA5A55A5A);
        chk("hold_fill", 32'(b8.fill), 32'd4);

        // Asynchronous reset in the middle of a shift sequence.
        step(1'b1, 1'b0, 2'b01, 8'h3C, 8'h00, 32'h0);
        step(1'b1, 1'b0, 2'b10, 8'h00, 8'hC3, 32'h0);
        do_reset();
        step(1'b1, 1'b0, 2'b01, 8'h77, 8'h00, 32'h0);
        chk("post_rst_fill", 32'(b8.fill), 32'd1);
        chk("post_rst_vl", 32'(b8.sout_l_valid), 32'd1);
        chk("post_rst_pout", b8.pout, 32'h00000077);

        @(negedge clk);
        #1;
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
